// File: rtl/seq_bcd_pkg.sv
// seq_bcd_pkg
// Shared definitions for the sequential BCD adder:
//   - state_t   : FSM state encoding (IDLE, LOAD, SHIFT, DONE)
//   - SEG_BLANK : active-low pattern for an unlit digit
//   - SEG_TABLE : digit-to-segment table, active-low, bit order gfedcba
//   - pow10     : helper used to check that DIGITS can hold the largest result
package seq_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the active-low segment pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec
// Combinational BCD digit to 7-segment decoder (active-low, gfedcba).
// Ports:
//   i_bcd : 4-bit BCD digit
//   o_seg : 7-bit active-low segments; codes above 9 show a blank digit
module seg7_dec
  import seq_bcd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Table lookup for legal digits, blank for anything that is not BCD.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_TABLE[i_bcd];
    end
  end

endmodule

// File: rtl/seq_bcd_adder.sv
// seq_bcd_adder
// Adds or subtracts two unsigned operands, converts the magnitude of the
// result to BCD with a sequential double-dabble (one bit per cycle) and
// drives a 7-segment pattern per digit with optional leading-zero blanking.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : request a conversion (only honoured in IDLE)
//   i_a, i_b       : unsigned operands
//   i_c_i          : carry-in (add) / borrow-in (subtract)
//   i_sub          : 0 = a+b+c_i, 1 = a-b-c_i
//   o_busy         : conversion in progress
//   o_done         : one-cycle pulse when outputs update
//   o_neg          : result sign (subtract only)
//   o_bcd          : result magnitude in BCD, digit 0 in [3:0]
//   o_seg          : active-low segments, digit 0 in [6:0]
module seq_bcd_adder
  import seq_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int BLANK  = 1
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_a,
  input  logic [WIDTH-1:0]      i_b,
  input  logic                  i_c_i,
  input  logic                  i_sub,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_neg,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [7*DIGITS-1:0]   o_seg
);

  localparam int RES_W = WIDTH + 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 2);

  // Reject parameter sets that cannot represent every possible result.
  if ((WIDTH < 2) || (WIDTH > 16)) begin : g_badWidth
    $error("seq_bcd_adder: WIDTH must be in 2..16");
  end
  if (pow10(DIGITS) <= ((longint'(1) << (WIDTH + 1)) - 1)) begin : g_badDigits
    $error("seq_bcd_adder: DIGITS too small for WIDTH+1-bit results");
  end

  state_t             r_state;
  state_t             w_nextState;
  logic               w_busy;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_ci;
  logic               r_sub;

  logic [RES_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_negWork;

  logic [BCD_W-1:0]   r_bcd;
  logic               r_neg;
  logic               r_done;

  logic [RES_W-1:0]   w_bPlusC;
  logic [RES_W-1:0]   w_sum;
  logic               w_isNeg;
  logic [RES_W-1:0]   w_diffMag;
  logic [RES_W-1:0]   w_result;
  logic [BCD_W-1:0]   w_adj;
  logic               w_lastIter;
  logic               w_seen;
  logic [DIGITS-1:0]  w_show;
  logic [7*DIGITS-1:0] w_decSeg;

  // Result formation on the captured operands. Folding the carry/borrow
  // into b first keeps every intermediate within WIDTH+1 bits; the largest
  // magnitude (0 - max - 1 = -2^WIDTH) still fits.
  assign w_bPlusC  = {1'b0, r_b} + {{WIDTH{1'b0}}, r_ci};
  assign w_sum     = {1'b0, r_a} + w_bPlusC;
  assign w_isNeg   = ({1'b0, r_a} < w_bPlusC);
  assign w_diffMag = w_isNeg ? (w_bPlusC - {1'b0, r_a}) : ({1'b0, r_a} - w_bPlusC);
  assign w_result  = r_sub ? w_diffMag : w_sum;

  assign w_lastIter = (r_cnt == CNT_W'(WIDTH));

  // State register; reset drops any conversion in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and busy decode.
  always_comb begin
    w_nextState = r_state;
    w_busy      = (r_state != IDLE);
    unique case (r_state)
      IDLE:    if (i_start) w_nextState = LOAD;
      LOAD:    w_nextState = SHIFT;
      SHIFT:   if (w_lastIter) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Double-dabble correction: any nibble of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
      end
    end
  end

  // Datapath: operand capture, result load, shift iterations and the
  // output update. The visible outputs only change in DONE, so they hold
  // the previous result for the whole conversion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_ci      <= 1'b0;
      r_sub     <= 1'b0;
      r_bin     <= '0;
      r_work    <= '0;
      r_cnt     <= '0;
      r_negWork <= 1'b0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_ci  <= i_c_i;
            r_sub <= i_sub;
          end
        end
        LOAD: begin
          r_bin     <= w_result;
          r_work    <= '0;
          r_cnt     <= '0;
          r_negWork <= r_sub & w_isNeg;
        end
        SHIFT: begin
          {r_work, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt           <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_bcd  <= r_work;
          r_neg  <= r_negWork;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Leading-zero blanking: scan from the top digit down; a digit is lit
  // once any digit at or above it is non-zero. Digit 0 is always lit.
  always_comb begin
    w_seen = 1'b0;
    w_show = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (r_bcd[4*i +: 4] != 4'd0) begin
        w_seen = 1'b1;
      end
      w_show[i] = w_seen || (i == 0) || (BLANK == 0);
    end
  end

  // Segments follow the registered BCD, so they update with it and show
  // the value 0 while in reset.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_dec u_dec (
      .i_bcd (r_bcd[4*g +: 4]),
      .o_seg (w_decSeg[7*g +: 7])
    );
    assign o_seg[7*g +: 7] = w_show[g] ? w_decSeg[7*g +: 7] : SEG_BLANK;
  end

  assign o_busy = w_busy;
  assign o_done = r_done;
  assign o_neg  = r_neg;
  assign o_bcd  = r_bcd;

endmodule

// File: tb/tb_seq_bcd_adder.sv
// tb_seq_bcd_adder
// Directed bench for seq_bcd_adder. Three instances share the stimulus:
// the default build (WIDTH=8, DIGITS=3, BLANK=1), the same without blanking,
// and a WIDTH=4, DIGITS=2 build fed with the low nibbles of the operands.
module tb_seq_bcd_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        c_i;
  logic        sub;

  logic        busy8, done8, neg8;
  logic [11:0] bcd8;
  logic [20:0] seg8;

  logic        busyNb, doneNb, negNb;
  logic [11:0] bcdNb;
  logic [20:0] segNb;

  logic        busy4, done4, neg4;
  logic [7:0]  bcd4;
  logic [13:0] seg4;

  int compared;
  int mismatched;
  int doneEdge8, doneCnt8;
  int doneEdge4, doneCnt4;
  int doneCntNb;

  seq_bcd_adder #(.WIDTH(8), .DIGITS(3), .BLANK(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
    .i_c_i(c_i), .i_sub(sub), .o_busy(busy8), .o_done(done8),
    .o_neg(neg8), .o_bcd(bcd8), .o_seg(seg8)
  );

  seq_bcd_adder #(.WIDTH(8), .DIGITS(3), .BLANK(0)) dutNb (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
    .i_c_i(c_i), .i_sub(sub), .o_busy(busyNb), .o_done(doneNb),
    .o_neg(negNb), .o_bcd(bcdNb), .o_seg(segNb)
  );

  seq_bcd_adder #(.WIDTH(4), .DIGITS(2), .BLANK(1)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a[3:0]), .i_b(b[3:0]),
    .i_c_i(c_i), .i_sub(sub), .o_busy(busy4), .o_done(done4),
    .o_neg(neg4), .o_bcd(bcd4), .o_seg(seg4)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present one request; start is sampled at the next rising edge (edge 0)
  // and dropped just after it.
  task automatic applyStimulus(input logic [7:0] aV, input logic [7:0] bV,
                               input logic ciV, input logic subV);
    @(negedge clk);
    a     = aV;
    b     = bV;
    c_i   = ciV;
    sub   = subV;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Watch a fixed number of edges after the start edge and record done
  // pulses. Optionally re-request (with new operands) so it is sampled at
  // restartEdge, or pull reset low just after rstEdge.
  task automatic runAndObserve(input int cycles, input int restartEdge,
                               input int rstEdge);
    doneEdge8 = -1; doneCnt8 = 0;
    doneEdge4 = -1; doneCnt4 = 0;
    doneCntNb = 0;
    for (int e = 1; e <= cycles; e++) begin
      @(posedge clk);
      #1;
      if (done8) begin
        doneCnt8++;
        if (doneEdge8 < 0) doneEdge8 = e;
      end
      if (done4) begin
        doneCnt4++;
        if (doneEdge4 < 0) doneEdge4 = e;
      end
      if (doneNb) doneCntNb++;
      if (e == restartEdge - 1) begin
        a     = 8'd99;
        b     = 8'd99;
        start = 1'b1;
      end
      if (e == restartEdge) start = 1'b0;
      if (e == rstEdge) begin
        rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", {31'd0, busy8}, 32'd0);
        checkOutput("midRstDone", {31'd0, done8}, 32'd0);
        checkOutput("midRstNeg",  {31'd0, neg8},  32'd0);
        checkOutput("midRstBcd",  {20'd0, bcd8},  32'd0);
        checkOutput("midRstSeg",  {11'd0, seg8},  {11'd0, 7'h7F, 7'h7F, 7'h40});
      end
      if (e == rstEdge + 1) rst_n = 1'b1;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    c_i   = 1'b0;
    sub   = 1'b0;

    // Reset state of all three builds.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy",  {31'd0, busy8}, 32'd0);
    checkOutput("rstDone",  {31'd0, done8}, 32'd0);
    checkOutput("rstNeg",   {31'd0, neg8},  32'd0);
    checkOutput("rstBcd",   {20'd0, bcd8},  32'd0);
    checkOutput("rstSeg",   {11'd0, seg8},  {11'd0, 7'h7F, 7'h7F, 7'h40});
    checkOutput("rstSegNb", {11'd0, segNb}, {11'd0, 7'h40, 7'h40, 7'h40});
    checkOutput("rstSeg4",  {18'd0, seg4},  {18'd0, 7'h7F, 7'h40});
    @(negedge clk);
    rst_n = 1'b1;

    // 255+255+1 = 511; WIDTH=4 build sees 15+15+1 = 31.
    applyStimulus(8'd255, 8'd255, 1'b1, 1'b0);
    checkOutput("t1Busy", {31'd0, busy8}, 32'd1);
    runAndObserve(14, -1, -1);
    checkOutput("t1DoneEdge", doneEdge8, 32'd11);
    checkOutput("t1DoneCnt",  doneCnt8,  32'd1);
    checkOutput("t1Bcd",  {20'd0, bcd8},  32'h511);
    checkOutput("t1Seg",  {11'd0, seg8},  {11'd0, 7'h12, 7'h79, 7'h79});
    checkOutput("t1SegNb", {11'd0, segNb}, {11'd0, 7'h12, 7'h79, 7'h79});
    checkOutput("t1Neg",  {31'd0, neg8},  32'd0);
    checkOutput("t1IdleBusy", {31'd0, busy8}, 32'd0);
    checkOutput("t1DoneEdge4", doneEdge4, 32'd7);
    checkOutput("t1DoneCnt4",  doneCnt4,  32'd1);
    checkOutput("t1Bcd4", {24'd0, bcd4}, 32'h31);
    checkOutput("t1Seg4", {18'd0, seg4}, {18'd0, 7'h30, 7'h79});

    // 3-10-0 = -7 on both widths.
    applyStimulus(8'd3, 8'd10, 1'b0, 1'b1);
    runAndObserve(14, -1, -1);
    checkOutput("t2Bcd",   {20'd0, bcd8},  32'h007);
    checkOutput("t2Neg",   {31'd0, neg8},  32'd1);
    checkOutput("t2Seg",   {11'd0, seg8},  {11'd0, 7'h7F, 7'h7F, 7'h78});
    checkOutput("t2SegNb", {11'd0, segNb}, {11'd0, 7'h40, 7'h40, 7'h78});
    checkOutput("t2Bcd4",  {24'd0, bcd4},  32'h07);
    checkOutput("t2Neg4",  {31'd0, neg4},  32'd1);
    checkOutput("t2Seg4",  {18'd0, seg4},  {18'd0, 7'h7F, 7'h78});

    // 5-4-1 = 0: a zero difference is not negative.
    applyStimulus(8'd5, 8'd4, 1'b1, 1'b1);
    runAndObserve(14, -1, -1);
    checkOutput("t3Bcd", {20'd0, bcd8}, 32'h000);
    checkOutput("t3Neg", {31'd0, neg8}, 32'd0);

    // 0+0+0 = 0 with and without blanking.
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0);
    runAndObserve(14, -1, -1);
    checkOutput("t4Bcd",   {20'd0, bcd8},  32'h000);
    checkOutput("t4Seg",   {11'd0, seg8},  {11'd0, 7'h7F, 7'h7F, 7'h40});
    checkOutput("t4SegNb", {11'd0, segNb}, {11'd0, 7'h40, 7'h40, 7'h40});
    checkOutput("t4DoneCntNb", doneCntNb, 32'd1);

    // 250+55 = 305: an inner zero digit stays lit.
    applyStimulus(8'd250, 8'd55, 1'b0, 1'b0);
    runAndObserve(14, -1, -1);
    checkOutput("t5Bcd", {20'd0, bcd8}, 32'h305);
    checkOutput("t5Seg", {11'd0, seg8}, {11'd0, 7'h30, 7'h40, 7'h12});

    // 0-255-1 = -256, the largest subtract magnitude.
    applyStimulus(8'd0, 8'd255, 1'b1, 1'b1);
    runAndObserve(14, -1, -1);
    checkOutput("t6Bcd", {20'd0, bcd8}, 32'h256);
    checkOutput("t6Neg", {31'd0, neg8}, 32'd1);
    checkOutput("t6Seg", {11'd0, seg8}, {11'd0, 7'h24, 7'h12, 7'h02});

    // Reset pulled mid-conversion: outputs clear at once, no done follows.
    applyStimulus(8'd123, 8'd45, 1'b0, 1'b0);
    runAndObserve(16, -1, 5);
    checkOutput("t7DoneCnt", doneCnt8, 32'd0);
    checkOutput("t7Bcd", {20'd0, bcd8}, 32'h000);

    // First request after reset converts normally: 9+8+1 = 18.
    applyStimulus(8'd9, 8'd8, 1'b1, 1'b0);
    runAndObserve(14, -1, -1);
    checkOutput("t8DoneEdge", doneEdge8, 32'd11);
    checkOutput("t8Bcd", {20'd0, bcd8}, 32'h018);
    checkOutput("t8Neg", {31'd0, neg8}, 32'd0);

    // Second request (99+99) sampled at edge 3 while busy is dropped;
    // the result stays 45+27 = 72 with exactly one done pulse.
    applyStimulus(8'd45, 8'd27, 1'b0, 1'b0);
    runAndObserve(20, 3, -1);
    checkOutput("t9DoneCnt",  doneCnt8,  32'd1);
    checkOutput("t9DoneEdge", doneEdge8, 32'd11);
    checkOutput("t9Bcd", {20'd0, bcd8}, 32'h072);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
